// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one simple dual-port block RAM (one write port, one read
// port, 1-cycle read latency) between requester 0 (CPU) and requester 1 (video).
// Write-port and read-port arbitration are independent each cycle, so one
// requester may write while the other reads. Same-address read/write in one
// cycle is resolved write-first by withholding the read for that cycle.
//
// Configuration macro: MEM_ARB_VIDEO_PRIO_EN
//   defined   - requester 1 wins both ports on contention (no pointers)
//   undefined - per-port round-robin using wptr / rptr
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   rN_req/we/addr/wdata        requester N request (held until rN_gnt)
//   rN_gnt                      single-cycle combinational grant
//   rN_rvalid                   read data valid, one cycle after a read grant
//   rdata                       shared read data (mem_dout pass-through)
//   mem_cea/mem_ada/mem_din     RAM write port
//   mem_ceb/mem_adb             RAM read port
//   mem_oce                     RAM output enable, tied high
//   mem_dout                    RAM read data
module mem_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_cea,
  output logic [ADDR_W-1:0] mem_ada,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_ceb,
  output logic [ADDR_W-1:0] mem_adb,
  output logic              mem_oce,
  input  logic [DATA_W-1:0] mem_dout
);

  // Candidate and winner signals; a winner select of 1 means requester 1.
  logic              w_cand0, w_cand1, r_cand0, r_cand1;
  logic              w_any, r_any;
  logic              w_sel, r_sel;
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic [DATA_W-1:0] w_data;
  logic              collision;
  logic              w_go, r_go;

  // Outstanding read: set in the grant cycle, drives rvalid the next cycle.
  logic              pending;
  logic              pending_id;

`ifndef MEM_ARB_VIDEO_PRIO_EN
  logic              wptr;
  logic              rptr;
`endif

  // Candidate selection and collision detection. Grants are suppressed
  // while resetn is low so nothing reaches the RAM during reset.
  always_comb begin
    w_cand0 = resetn & r0_req & r0_we;
    w_cand1 = resetn & r1_req & r1_we;
    r_cand0 = resetn & r0_req & ~r0_we;
    r_cand1 = resetn & r1_req & ~r1_we;
    w_any   = w_cand0 | w_cand1;
    r_any   = r_cand0 | r_cand1;

`ifdef MEM_ARB_VIDEO_PRIO_EN
    // Requester 1 wins whenever it is a candidate.
    w_sel = w_cand1;
    r_sel = r_cand1;
`else
    // Pointer decides only under contention; otherwise the lone candidate wins.
    w_sel = (w_cand0 & w_cand1) ? wptr : w_cand1;
    r_sel = (r_cand0 & r_cand1) ? rptr : r_cand1;
`endif

    w_addr = w_sel ? r1_addr  : r0_addr;
    w_data = w_sel ? r1_wdata : r0_wdata;
    r_addr = r_sel ? r1_addr  : r0_addr;

    // Write-first: a same-address read waits one cycle, after the write lands.
    collision = w_any & r_any & (w_addr == r_addr);
    w_go      = w_any;
    r_go      = r_any & ~collision;
  end

  // Grant and RAM port drive; idle ports present zero address/data.
  always_comb begin
    r0_gnt  = 1'b0;
    r1_gnt  = 1'b0;
    mem_cea = 1'b0;
    mem_ada = '0;
    mem_din = '0;
    mem_ceb = 1'b0;
    mem_adb = '0;

    if (w_go) begin
      mem_cea = 1'b1;
      mem_ada = w_addr;
      mem_din = w_data;
      if (w_sel) begin
        r1_gnt = 1'b1;
      end else begin
        r0_gnt = 1'b1;
      end
    end

    if (r_go) begin
      mem_ceb = 1'b1;
      mem_adb = r_addr;
      if (r_sel) begin
        r1_gnt = 1'b1;
      end else begin
        r0_gnt = 1'b1;
      end
    end
  end

  // Read response path: RAM output is passed straight through.
  assign rdata     = mem_dout;
  assign mem_oce   = 1'b1;
  assign r0_rvalid = pending & ~pending_id;
  assign r1_rvalid = pending & pending_id;

  // Pending read tracking; reset drops any read in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending    <= 1'b0;
      pending_id <= 1'b0;
    end else begin
      pending <= r_go;
      if (r_go) begin
        pending_id <= r_sel;
      end
    end
  end

`ifdef MEM_ARB_VIDEO_PRIO_EN
`else
  // Round-robin pointers: after a grant, favour the other requester.
  // A withheld read does not move rptr.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      if (w_go) begin
        wptr <= ~w_sel;
      end
      if (r_go) begin
        rptr <= ~r_sel;
      end
    end
  end
`endif

endmodule
